serial_adder: RTL and testbench

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder_pkg.sv | 12 +
 rtl/full_adder.sv | 13 +
 rtl/serial_adder.sv | 106 ++++++++++
 tb/tb_serial_adder.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and default width.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/full_adder.sv
// One-bit combinational full adder; the adding counterpart of the full_subtractor cell.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: consumes one operand bit pair per cycle, LSB first, through a
// single full_adder, and publishes sum/cout only when all WIDTH bits are done.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int                CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_part;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_cout;
  logic             r_busy;
  logic             r_done;
  logic [CNT_W-1:0] r_cnt;

  logic             w_sum_bit;
  logic             w_carry;
  logic [WIDTH-1:0] w_part_next;

  full_adder u_fa (
    .a    (r_a[0]),
    .b    (r_b[0]),
    .cin  (r_carry),
    .sum  (w_sum_bit),
    .cout (w_carry)
  );

  // New sum bits enter at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
  assign w_part_next = {w_sum_bit, r_part[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_part  <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= cin;
            r_part  <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_a     <= r_a >> 1;
          r_b     <= r_b >> 1;
          r_carry <= w_carry;
          r_part  <= w_part_next;
          r_cnt   <= r_cnt + CNT_W'(1);
          if (r_cnt == LAST_BIT) begin
            r_sum   <= w_part_next;
            r_cout  <= w_carry;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign sum  = r_sum;
  assign cout = r_cout;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: WIDTH=8 and WIDTH=4 instances checked every cycle against a
// transaction-level model (operands summed arithmetically, latency counted down).
module tb_serial_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       s8, c8, s4, c4;
  logic [7:0] a8, b8;
  logic [3:0] a4, b4;
  logic       busy8, done8, cout8, busy4, done4, cout4;
  logic [7:0] sum8;
  logic [3:0] sum4;

  serial_adder #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(s8), .a(a8), .b(b8), .cin(c8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_adder #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(s4), .a(a4), .b(b4), .cin(c4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
  );

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction model: an accepted request finishes WIDTH edges later with a+b+cin,
  // then one done cycle during which start is not looked at.
  int         m8_rem = 0, m4_rem = 0;
  bit         m8_done = 0, m4_done = 0;
  logic [8:0] m8_res = '0, m8_out = '0;
  logic [4:0] m4_res = '0, m4_out = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m8_rem <= 0; m8_done <= 0; m8_out <= '0;
    end else if (m8_rem > 0) begin
      m8_rem <= m8_rem - 1;
      if (m8_rem == 1) begin m8_done <= 1; m8_out <= m8_res; end
    end else if (m8_done) begin
      m8_done <= 0;
    end else if (s8) begin
      m8_res <= {1'b0, a8} + {1'b0, b8} + {8'd0, c8};
      m8_rem <= 8;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m4_rem <= 0; m4_done <= 0; m4_out <= '0;
    end else if (m4_rem > 0) begin
      m4_rem <= m4_rem - 1;
      if (m4_rem == 1) begin m4_done <= 1; m4_out <= m4_res; end
    end else if (m4_done) begin
      m4_done <= 0;
    end else if (s4) begin
      m4_res <= {1'b0, a4} + {1'b0, b4} + {4'd0, c4};
      m4_rem <= 4;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy8", busy8, m8_rem != 0);
      chk("done8", done8, m8_done);
      chk("sum8",  sum8,  m8_out[7:0]);
      chk("cout8", cout8, m8_out[8]);
      chk("busy4", busy4, m4_rem != 0);
      chk("done4", done4, m4_done);
      chk("sum4",  sum4,  m4_out[3:0]);
      chk("cout4", cout4, m4_out[4]);
    end
  end

  // One WIDTH=8 operation with literal expectations; inputs are scrambled after
  // acceptance, and optionally a second start is pulsed at RUN cycle 3.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c,
                     input logic [7:0] es, input logic ec, input bit inj);
    int  nbusy;
    bit  seen;
    nbusy = 0;
    seen  = 0;
    @(negedge clk);
    s8 = 1'b1; a8 = a; b8 = b; c8 = c;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (i == 0) begin
        s8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom);
      end
      if (inj && i == 2) begin s8 = 1'b1; a8 = 8'hAA; b8 = 8'h55; end
      if (inj && i == 3) s8 = 1'b0;
      if (done8) begin seen = 1; break; end
      if (busy8) nbusy++;
    end
    if (!seen) begin
      chk("op8_done_timeout", 0, 1);
    end else begin
      chk("op8_sum", sum8, es);
      chk("op8_cout", cout8, ec);
      chk("op8_busy_len", nbusy, 8);
    end
  endtask

  initial begin
    int last, nd;
    rst_n = 1'b1;
    s8 = 0; a8 = '0; b8 = '0; c8 = 0;
    s4 = 0; a4 = '0; b4 = '0; c4 = 0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_busy8", busy8, 0);
    chk("rst_done8", done8, 0);
    chk("rst_sum8",  sum8,  0);
    chk("rst_cout8", cout8, 0);
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    op8(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 0);
    op8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 0);
    op8(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 0);
    op8(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1);
    nd = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (busy8 || done8) nd++;
    end
    chk("ignored_start_no_op", nd, 0);

    // start held high: a completion every WIDTH+2 cycles
    @(negedge clk);
    s8 = 1'b1; a8 = 8'h7F; b8 = 8'h01; c8 = 1'b0;
    last = -1;
    nd   = 0;
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      if (done8) begin
        chk("held_sum", sum8, 8'h80);
        chk("held_cout", cout8, 0);
        if (last >= 0) chk("held_period", i - last, 10);
        last = i;
        nd++;
      end
    end
    chk("held_count", nd, 4);
    s8 = 1'b0;
    repeat (14) @(negedge clk);

    // reset mid-RUN aborts without a done pulse
    @(negedge clk);
    s8 = 1'b1; a8 = 8'h80; b8 = 8'h80; c8 = 1'b0;
    @(negedge clk);
    s8 = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy8", busy8, 0);
    chk("abort_done8", done8, 0);
    chk("abort_sum8",  sum8,  0);
    chk("abort_cout8", cout8, 0);
    @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done8) nd++;
    end
    chk("abort_no_done", nd, 0);
    op8(8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 0);

    // randomized traffic on both instances, operands changing every cycle
    for (int i = 0; i < 2500; i++) begin
      @(negedge clk);
      s8 = ($urandom_range(0, 3) == 0);
      a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom);
      s4 = ($urandom_range(0, 2) == 0);
      a4 = 4'($urandom); b4 = 4'($urandom); c4 = 1'($urandom);
    end
    s8 = 1'b0;
    s4 = 1'b0;
    repeat (14) @(negedge clk);

    // exhaustive WIDTH=4 sweep
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        for (int ic = 0; ic < 2; ic++) begin
          logic [4:0] exp5;
          bit         seen;
          exp5 = 5'(ia) + 5'(ib) + 5'(ic);
          seen = 0;
          @(negedge clk);
          s4 = 1'b1; a4 = 4'(ia); b4 = 4'(ib); c4 = 1'(ic);
          for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (k == 0) begin s4 = 1'b0; a4 = ~a4; b4 = ~b4; c4 = ~c4; end
            if (done4) begin seen = 1; break; end
          end
          if (!seen) chk("exh4_done_timeout", 0, 1);
          else       chk("exh4_result", {cout4, sum4}, exp5);
        end
      end
    end

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
